// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: per-instruction tracking info.
package mem_stage_pkg;

   localparam int unsigned PC_W      = 32;
   localparam int unsigned INST_W    = 32;
   localparam int unsigned INST_ID_W = 16;

   typedef struct packed {
      logic [PC_W-1:0]      pc;
      logic [INST_W-1:0]    inst;
      logic [INST_ID_W-1:0] inst_id;
   } stage_info_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage between execute and write-back: data-memory access, load alignment/extension.
// Optional MEM_ACCESS_LOG_EN adds access counters and a per-access log line.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  stage_info_t       info,
   input  logic              mem_en,
   input  logic              mem_wen,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   exe_result,
   input  logic              rf_wen,
   input  logic [4:0]        reg_addr,
   output logic              stall,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic              req_wen,
   output logic [XLEN-1:0]   req_wdata,
   output logic [3:0]        req_wmask,
   input  logic              resp_valid,
   input  logic [XLEN-1:0]   resp_rdata,
   output logic              wb_valid,
   output stage_info_t       wb_info,
   output logic              wb_rf_wen,
   output logic [4:0]        wb_reg_addr,
   output logic [XLEN-1:0]   wb_wdata,
   output logic              misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state, state_d;

   // access context captured on acceptance
   stage_info_t       l_info;
   logic              l_wen, l_uns, l_rf_wen;
   logic [1:0]        l_size, l_lane;
   logic [4:0]        l_reg_addr;
   logic [ADDR_W-1:0] l_addr;
   logic [XLEN-1:0]   l_wdata;
   logic [3:0]        l_wmask;

   logic              mis_c, latch_c;
   logic [XLEN-1:0]   st_data_c, ld_shift_c, ld_data_c;
   logic [3:0]        st_mask_c;

   logic              wb_valid_d, wb_rf_wen_d, mis_d;
   stage_info_t       wb_info_d;
   logic [4:0]        wb_reg_addr_d;
   logic [XLEN-1:0]   wb_wdata_d;

   always_comb begin
      case (mem_size)
         2'd0:    mis_c = 1'b0;
         2'd1:    mis_c = addr[0];
         2'd2:    mis_c = |addr[1:0];
         default: mis_c = 1'b1;
      endcase
   end

   // store lane replication and byte enables
   always_comb begin
      st_data_c = store_data;
      st_mask_c = 4'b1111;
      case (mem_size)
         2'd0: begin
            st_data_c = {(XLEN/8){store_data[7:0]}};
            st_mask_c = 4'b0001 << addr[1:0];
         end
         2'd1: begin
            st_data_c = {(XLEN/16){store_data[15:0]}};
            st_mask_c = 4'b0011 << addr[1:0];
         end
         default: ;
      endcase
   end

   // load lane select and extension; aligned words have lane 0
   assign ld_shift_c = resp_rdata >> {l_lane, 3'b000};

   always_comb begin
      ld_data_c = ld_shift_c;
      case (l_size)
         2'd0: ld_data_c = l_uns ? XLEN'(ld_shift_c[7:0])
                                 : {{(XLEN-8){ld_shift_c[7]}}, ld_shift_c[7:0]};
         2'd1: ld_data_c = l_uns ? XLEN'(ld_shift_c[15:0])
                                 : {{(XLEN-16){ld_shift_c[15]}}, ld_shift_c[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state;
      latch_c       = 1'b0;
      wb_valid_d    = 1'b0;
      wb_rf_wen_d   = 1'b0;
      mis_d         = 1'b0;
      wb_info_d     = wb_info;
      wb_reg_addr_d = wb_reg_addr;
      wb_wdata_d    = wb_wdata;
      case (state)
         IDLE: begin
            if (valid) begin
               if (!mem_en) begin
                  wb_valid_d    = 1'b1;
                  wb_info_d     = info;
                  wb_rf_wen_d   = rf_wen;
                  wb_reg_addr_d = reg_addr;
                  wb_wdata_d    = exe_result;
               end else if (mis_c) begin
                  wb_valid_d    = 1'b1;
                  wb_info_d     = info;
                  wb_reg_addr_d = reg_addr;
                  wb_wdata_d    = '0;
                  mis_d         = 1'b1;
               end else begin
                  latch_c = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (req_ready) state_d = RESP;
         end
         RESP: begin
            if (resp_valid) begin
               state_d       = IDLE;
               wb_valid_d    = 1'b1;
               wb_info_d     = l_info;
               wb_rf_wen_d   = l_rf_wen & ~l_wen;
               wb_reg_addr_d = l_reg_addr;
               wb_wdata_d    = l_wen ? '0 : ld_data_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         l_info      <= '0;
         l_wen       <= 1'b0;
         l_uns       <= 1'b0;
         l_rf_wen    <= 1'b0;
         l_size      <= 2'd0;
         l_lane      <= 2'd0;
         l_reg_addr  <= 5'd0;
         l_addr      <= '0;
         l_wdata     <= '0;
         l_wmask     <= 4'd0;
         wb_valid    <= 1'b0;
         wb_info     <= '0;
         wb_rf_wen   <= 1'b0;
         wb_reg_addr <= 5'd0;
         wb_wdata    <= '0;
         misaligned  <= 1'b0;
      end else begin
         state       <= state_d;
         wb_valid    <= wb_valid_d;
         wb_info     <= wb_info_d;
         wb_rf_wen   <= wb_rf_wen_d;
         wb_reg_addr <= wb_reg_addr_d;
         wb_wdata    <= wb_wdata_d;
         misaligned  <= mis_d;
         if (latch_c) begin
            l_info     <= info;
            l_wen      <= mem_wen;
            l_uns      <= mem_unsigned;
            l_rf_wen   <= rf_wen;
            l_size     <= mem_size;
            l_lane     <= addr[1:0];
            l_reg_addr <= reg_addr;
            l_addr     <= {addr[ADDR_W-1:2], 2'b00};
            l_wdata    <= st_data_c;
            l_wmask    <= st_mask_c;
         end
      end
   end

   assign stall     = (state != IDLE) | (valid & mem_en & ~mis_c);
   assign req_valid = (state == REQ);
   assign req_addr  = l_addr;
   assign req_wen   = l_wen;
   assign req_wdata = l_wdata;
   assign req_wmask = l_wmask;

`ifdef MEM_ACCESS_LOG_EN
   logic [63:0] n_loads, n_stores, n_misaligned, n_stall_cycles;
   logic        wb_mem;

   // context registers still hold the access while its wb_valid is visible
   always_ff @(posedge clk) begin
      if (reset) begin
         n_loads        <= 64'd0;
         n_stores       <= 64'd0;
         n_misaligned   <= 64'd0;
         n_stall_cycles <= 64'd0;
         wb_mem         <= 1'b0;
      end else begin
         wb_mem <= (state == RESP) & resp_valid;
         if (stall) n_stall_cycles <= n_stall_cycles + 64'd1;
         if ((state == IDLE) & valid & mem_en & mis_c) n_misaligned <= n_misaligned + 64'd1;
         if ((state == RESP) & resp_valid) begin
            if (l_wen) n_stores <= n_stores + 64'd1;
            else       n_loads  <= n_loads + 64'd1;
         end
         if (wb_valid & wb_mem & util::logEnabled())
            $display("mem,%h,%h,%s,%h", wb_info.pc, {l_addr[ADDR_W-1:2], l_lane},
                     l_wen ? "S" : "L", l_wen ? l_wdata : wb_wdata);
      end
   end
`else
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly upstream of the write-back stage. Takes one instruction per handshake from the execute stage.
- Loads and stores: performs the data-memory access, aligns and extends load data, and drives the write-back stage inputs (valid, info, rf_wen, reg_addr, wdata).
- Non-memory instructions: passes the execute result through with one register of latency.

Parameters:
XLEN, 32, datapath width; only 32 is supported (word = 4 bytes).
ADDR_W, 32, data-memory address width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
valid  in  1  execute stage presents an instruction.
info  in  StageInfo  pc/inst/inst_id of the instruction.
mem_en  in  1  instruction is a load or store.
mem_wen  in  1  1 = store, 0 = load (meaningful only when mem_en=1).
mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
mem_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
addr  in  ADDR_W  effective address.
store_data  in  XLEN  rs2 value.
exe_result  in  XLEN  ALU result for non-memory instructions.
rf_wen  in  1  instruction writes rd.
reg_addr  in  5  rd.
stall  out  1  upstream must hold all inputs stable while 1.
req_valid  out  1  memory request.
req_ready  in  1  memory accepts request.
req_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 0).
req_wen  out  1  store request.
req_wdata  out  XLEN  lane-shifted store data.
req_wmask  out  4  byte enables.
resp_valid  in  1  read data or store acknowledge.
resp_rdata  in  XLEN  raw read word.
wb_valid  out  1  to write-back valid.
wb_info  out  StageInfo  to write-back info.
wb_rf_wen  out  1  to write-back rf_wen.
wb_reg_addr  out  5  to write-back reg_addr.
wb_wdata  out  XLEN  to write-back wdata.
misaligned  out  1  pulses together with wb_valid for a misaligned or illegal access.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Reset mid-access abandons the access; a resp_valid arriving later while in IDLE is ignored.
- States:
  - IDLE.
    - valid & !mem_en → register to wb_* next cycle (wb_wdata = exe_result); remain in IDLE.
    - valid & mem_en & misaligned → wb_valid next cycle with wb_rf_wen = 0 and misaligned = 1; no memory request.
    - valid & mem_en & aligned → latch all inputs, go to REQ.
  - REQ: req_valid = 1. Address and data stay stable until req_ready. Do not withdraw the request. On req_valid & req_ready go to RESP.
  - RESP: wait for resp_valid. In the cycle it arrives, go to IDLE. wb_* are registered and visible on the next cycle.
- Misaligned definition:
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - mem_size = 3.
- stall = (state != IDLE) | (state == IDLE & valid & mem_en & aligned).
- wb_valid: exactly one cycle per accepted instruction, and 0 in all other cycles.
- Load data:
  - shifted = resp_rdata >> (8*addr[1:0]), using the latched addr;
  - keep 8 or 16 bits for byte or half, then sign- or zero-extend per mem_unsigned;
  - word loads pass through unchanged.
  - wb_rf_wen = latched rf_wen.
- Store:
  - req_wdata = store_data replicated across byte lanes (byte ×4, half ×2);
  - req_wmask = (0001, 0011 or 1111) << addr[1:0];
  - wb_valid is still produced on the acknowledge, with wb_rf_wen = 0.
- reg_addr 0 with rf_wen = 1 is passed through unchanged; the write-back stage discards it.
- Latency:
  - non-memory instruction: 1 cycle;
  - memory access with req_ready and resp_valid each asserted one cycle after they become possible: 3 cycles from acceptance to wb_valid.
- resp_valid while in IDLE or REQ: ignored.

Optional Feature:
- Macro: MEM_ACCESS_LOG_EN.
- Defined:
  - 64-bit counters for completed loads, completed stores, misaligned accesses and stall cycles;
  - on each memory wb_valid, $display "mem,<pc>,<addr>,<L|S>,<data>" when util::logEnabled().
- Undefined: no counters and no prints; ports and timing are identical.

Test Plan:
- ALU pass-through: valid, mem_en = 0, exe_result = 0x1234, rd = 5 → next cycle wb_valid = 1, wb_wdata = 0x1234, wb_reg_addr = 5; stall stays 0.
- lb, signed: addr = 0x103, resp_rdata = 0x80FFFFFF → req_addr = 0x100, wb_wdata = 0xFFFFFF80; with mem_unsigned = 1 → 0x00000080.
- sh: addr = 0x202, store_data = 0xABCD → req_wdata = 0xABCDABCD, req_wmask = 1100, wb_rf_wen = 0 after the acknowledge.
- req_ready held low for 5 cycles → req_valid, req_addr and stall stay stable for all 5; exactly one wb_valid afterwards.
- lw at addr = 0x101 → no req_valid, misaligned = 1 together with wb_valid, wb_rf_wen = 0.
- Reset asserted while in RESP, then resp_valid pulses → no wb_valid, state IDLE, stall = 0.
